// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control sequencer: state encodings,
// default widths and the same-cycle button event ordering.
package stopwatch_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } sw_state_e;

  localparam int DIV_W_DEF = 24;
  localparam int DEB_W_DEF = 16;

  typedef struct packed {
    logic clr;
    logic ss;
    logic lap;
  } sw_events_t;

  // clr outranks ss, which outranks lap; losers in the same cycle are dropped
  function automatic sw_events_t prioritize_events(input logic clr, input logic ss,
                                                   input logic lap);
    sw_events_t ev;
    ev.clr = clr;
    ev.ss  = ss & ~clr;
    ev.lap = lap & ~ss & ~clr;
    return ev;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Raw push-button conditioner: 2-flop synchronizer, level debounce and a
// single-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int DEB_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);

  logic             sync_1;
  logic             sync_2;
  logic             stable;
  logic [DEB_W-1:0] deb_cnt;
  logic [DEB_W-1:0] cnt_inc;

  assign cnt_inc = deb_cnt + 1'b1;

  // stable flips on the edge where the count would reach all-ones, so a new
  // level must be seen for 2^DEB_W-1 consecutive cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      stable  <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      press  <= 1'b0;
      if (sync_2 != stable) begin
        if (&cnt_inc) begin
          stable  <= sync_2;
          deb_cnt <= '0;
          press   <= sync_2;
        end else begin
          deb_cnt <= cnt_inc;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: decides when the BCD datapath counts, clears
// or freezes its display.
//
//   state | meaning
//   IDLE  | cleared, waiting for start
//   RUN   | prescaler running, count ticks issued
//   PAUSE | prescaler frozen at its partial value
//   DONE  | terminal count reached, only clear leaves
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEB_W = DEB_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic       tc,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [1:0] state
);

  logic             p_ss;
  logic             p_lap;
  logic             p_clr;
  sw_events_t       ev;
  sw_state_e        state_q;
  sw_state_e        state_nxt;
  logic [DIV_W-1:0] presc_q;
  logic [DIV_W-1:0] presc_nxt;
  logic             tick;
  logic             en_nxt;
  logic             clr_nxt;
  logic             hold_nxt;

  btn_debounce #(.DEB_W(DEB_W)) u_deb_ss  (.clk(clk), .rst(rst), .btn(btn_ss),  .press(p_ss));
  btn_debounce #(.DEB_W(DEB_W)) u_deb_lap (.clk(clk), .rst(rst), .btn(btn_lap), .press(p_lap));
  btn_debounce #(.DEB_W(DEB_W)) u_deb_clr (.clk(clk), .rst(rst), .btn(btn_clr), .press(p_clr));

  assign tick  = (state_q == RUN) && (&presc_q);
  assign state = state_q;

  always_comb begin
    ev        = prioritize_events(p_clr, p_ss, p_lap);
    state_nxt = state_q;
    presc_nxt = presc_q;
    en_nxt    = 1'b0;
    clr_nxt   = 1'b0;
    hold_nxt  = disp_hold;

    if (state_q == RUN) presc_nxt = presc_q + 1'b1;

    case (state_q)
      IDLE: begin
        if (ev.ss) begin
          state_nxt = RUN;
          presc_nxt = '0;
        end
      end
      RUN: begin
        if (ev.ss)           state_nxt = PAUSE;
        else if (tick && tc) state_nxt = DONE;
        if (tick && !tc) en_nxt = 1'b1;
        if (ev.lap) hold_nxt = ~disp_hold;
      end
      PAUSE: begin
        if (ev.ss)  state_nxt = RUN;
        if (ev.lap) hold_nxt = ~disp_hold;
      end
      DONE: begin
      end
      default: state_nxt = IDLE;
    endcase

    // clear wins over everything, including a tick landing in the same cycle
    if (ev.clr) begin
      state_nxt = IDLE;
      clr_nxt   = 1'b1;
      en_nxt    = 1'b0;
      hold_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_en    <= 1'b0;
      cnt_clr   <= 1'b0;
      disp_hold <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      presc_q   <= presc_nxt;
      cnt_en    <= en_nxt;
      cnt_clr   <= clr_nxt;
      disp_hold <= hold_nxt;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with DIV_W=4, DEB_W=2: exact-timing
// sequences plus a table of button windows with hand-computed outcomes.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lap;
  logic       btn_clr;
  logic       tc;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_hold;
  logic [1:0] state;

  stopwatch_ctrl #(.DIV_W(4), .DEB_W(2)) dut (
    .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .tc(tc), .cnt_en(cnt_en), .cnt_clr(cnt_clr), .disp_hold(disp_hold), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ss;
    logic       lap;
    logic       clr;
    logic       tc;
    int         win;
    logic [1:0] exp_state;
    logic       exp_hold;
    int         exp_en;
    int         exp_clr;
    logic       exp_ran;
  } vec_t;

  vec_t       vt[12];
  int         total = 0;
  int         bad = 0;
  int         en_cnt = 0;
  int         clr_cnt = 0;
  int         both_cnt = 0;
  int         trans = 0;
  logic       ran = 1'b0;
  logic [1:0] st_prev = 2'd0;
  int         n;
  int         e0;
  int         c0;

  task automatic step();
    @(negedge clk);
    if (cnt_en) en_cnt++;
    if (cnt_clr) clr_cnt++;
    if (cnt_en && cnt_clr) both_cnt++;
    if (state == 2'd1) ran = 1'b1;
    if (state != st_prev) trans++;
    st_prev = state;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    //       ss    lap   clr   tc    win st     hold  en clr ran
    vt[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32, 2'd1, 1'b1, 2, 0, 1'b1};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32, 2'd1, 1'b0, 2, 0, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32, 2'd1, 1'b1, 2, 0, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 16, 2'd3, 1'b1, 0, 0, 1'b1};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 16, 2'd3, 1'b1, 0, 0, 1'b0};
    vt[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16, 2'd3, 1'b1, 0, 0, 1'b0};
    vt[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16, 2'd0, 1'b0, 0, 1, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16, 2'd0, 1'b0, 0, 0, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 22, 2'd1, 1'b0, 1, 0, 1'b1};
    vt[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16, 2'd1, 1'b1, 1, 0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16, 2'd2, 1'b1, 0, 0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 16, 2'd0, 1'b0, 0, 1, 1'b0};

    rst = 1'b1; btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0; tc = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    step();
    check("reset_state", int'(state), 0);
    check("reset_cnt_en", int'(cnt_en), 0);
    check("reset_cnt_clr", int'(cnt_clr), 0);
    check("reset_disp_hold", int'(disp_hold), 0);

    // start: press accepted 5 edges after first sample, RUN on the 6th
    btn_ss = 1'b1;
    repeat (5) step();
    check("t1_still_idle", int'(state), 0);
    step();
    check("t1_run", int'(state), 1);
    n = 1;
    while (!cnt_en && n < 40) begin
      step();
      n++;
      if (n == 5) btn_ss = 1'b0;
    end
    check("t1_first_en_cycle", n, 17);
    for (int p = 0; p < 2; p++) begin
      n = 0;
      do begin
        step();
        n++;
      end while (!cnt_en && n < 40);
      check("t1_en_period", n, 16);
    end

    // pause with prescaler at 9, then resume keeps the partial period
    repeat (3) step();
    btn_ss = 1'b1;
    repeat (5) step();
    check("t2_run_before_pause", int'(state), 1);
    step();
    check("t2_pause", int'(state), 2);
    repeat (4) step();
    btn_ss = 1'b0;
    e0 = en_cnt;
    repeat (40) step();
    check("t2_no_en_in_pause", en_cnt - e0, 0);
    check("t2_still_pause", int'(state), 2);
    btn_ss = 1'b1;
    repeat (6) step();
    check("t2_resume", int'(state), 1);
    n = 1;
    while (!cnt_en && n < 40) begin
      step();
      n++;
      if (n == 5) btn_ss = 1'b0;
    end
    check("t2_resume_en_cycle", n, 8);

    // table windows: lap toggles, DONE entry, ignored buttons, clear priority
    for (int i = 0; i < 12; i++) begin
      btn_ss = vt[i].ss; btn_lap = vt[i].lap; btn_clr = vt[i].clr; tc = vt[i].tc;
      e0 = en_cnt;
      c0 = clr_cnt;
      ran = 1'b0;
      for (int k = 1; k <= vt[i].win; k++) begin
        step();
        if (k == 10) begin
          btn_ss = 1'b0; btn_lap = 1'b0; btn_clr = 1'b0;
        end
      end
      check($sformatf("vec%0d_state", i), int'(state), int'(vt[i].exp_state));
      check($sformatf("vec%0d_hold", i), int'(disp_hold), int'(vt[i].exp_hold));
      check($sformatf("vec%0d_en_pulses", i), en_cnt - e0, vt[i].exp_en);
      check($sformatf("vec%0d_clr_pulses", i), clr_cnt - c0, vt[i].exp_clr);
      check($sformatf("vec%0d_ran", i), int'(ran), int'(vt[i].exp_ran));
    end
    tc = 1'b0;

    // bouncing start button gives exactly one press
    trans = 0;
    for (int i = 0; i < 8; i++) begin
      btn_ss = (i % 2 == 0);
      step();
    end
    btn_ss = 1'b1;
    repeat (10) step();
    btn_ss = 1'b0;
    check("t6_bounce_run", int'(state), 1);
    repeat (10) step();
    check("t6_bounce_one_press", trans, 1);
    n = 0;
    while (!cnt_en && n < 40) begin
      step();
      n++;
    end
    check("t6_en_seen", int'(cnt_en), 1);

    // reset on the edge where a tick would have produced cnt_en
    repeat (15) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_state", int'(state), 0);
    check("t6_rst_cnt_en", int'(cnt_en), 0);
    check("t6_rst_cnt_clr", int'(cnt_clr), 0);
    e0 = en_cnt;
    c0 = clr_cnt;
    repeat (20) step();
    check("t6_idle_no_en", en_cnt - e0, 0);
    check("t6_idle_no_clr", clr_cnt - c0, 0);
    check("t6_idle_state", int'(state), 0);

    check("never_en_and_clr", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
